// File: rtl/game_status_pkg.sv
// Shared definitions for the game status controller.
// Holds the status codes, the result codes, the peer code sets used by the
// sequencer, and a helper that checks every active peer against a code set.
package game_status_pkg;

  // Upper bound on remote opponents; peer vectors are widened to this size
  // before being handed to the helper function.
  localparam int unsigned MAX_PEERS = 3;

  typedef enum logic [2:0] {
    STAT_NORMAL        = 3'b000,
    STAT_MATCH_ING     = 3'b001,
    STAT_MATCH_CANCEL  = 3'b010,
    STAT_MATCH_SUCCESS = 3'b011,
    STAT_GAME_INITIAL  = 3'b100,
    STAT_GAME_CNTDOWN  = 3'b101,
    STAT_GAME_ING      = 3'b110,
    STAT_GAME_OVER     = 3'b111
  } stat_e;

  typedef enum logic [1:0] {
    RES_NONE  = 2'd0,
    RES_WIN   = 2'd1,
    RES_LOSE  = 2'd2,
    RES_ABORT = 2'd3
  } res_e;

  // Code sets as one-hot masks indexed by the 3-bit peer code.
  localparam logic [7:0] SET_SEARCH = 8'b0000_1010; // MATCH_ING or MATCH_SUCCESS
  localparam logic [7:0] SET_READY  = 8'b1111_1000; // MATCH_SUCCESS or later
  localparam logic [7:0] SET_OVER   = 8'b1000_0000; // GAME_OVER only

  // True when each of the first n peers reports a code contained in codes.
  function automatic logic peers_in_set(input logic [3*MAX_PEERS-1:0] stat,
                                        input int unsigned            n,
                                        input logic [7:0]             codes);
    logic ok;
    ok = 1'b1;
    for (int unsigned i = 0; i < MAX_PEERS; i++) begin
      if (i < n && !codes[stat[3*i +: 3]]) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/tick_down_cnt.sv
// Loadable down counter enabled by a tick strobe.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset (count -> 0)
//   clr         synchronous clear to 0 (highest priority)
//   load        synchronous load of load_val
//   load_val    value loaded on load
//   en          decrement enable (one-cycle tick)
//   count       current count; saturates at 0
//   term        count == 1, i.e. the next enabled tick is the last one
module tick_down_cnt #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             term
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && count != '0) begin
      count <= count - WIDTH'(1);
    end
  end

  assign term = (count == WIDTH'(1));

endmodule

// File: rtl/game_status_ctrl.sv
// Game status sequencer for a local player versus 1..NUM_PEERS opponents.
// Walks NORMAL -> (matchmaking) -> GAME_INITIAL -> GAME_CNTDOWN -> GAME_ING
// -> GAME_OVER, with match timeout, single-player pause and a result code.
// Ports:
//   global_clk, rst_n  clock, asynchronous active-low reset
//   pb_ctl, pb_pause   one-cycle button pulses
//   dip_players        1 = multiplayer (sampled only when leaving NORMAL)
//   game_tick          one-cycle timing strobe
//   peer_stat          3-bit status code per peer, peer i at [3i+2:3i]
//   peer_valid         link-alive flag per peer
//   table_ready        board cleared and ready
//   top_out            local stack overflow (local player lost)
//   stat_out           current status code
//   cntdown_val        countdown digit
//   paused             single-player pause active
//   result             0 none, 1 win, 2 lose, 3 abort
//   stat_chg           high in the first cycle of a new stat_out value
module game_status_ctrl
  import game_status_pkg::*;
#(
  parameter int unsigned NUM_PEERS     = 1,
  parameter int unsigned CNT_SECS      = 3,
  parameter int unsigned MATCH_TIMEOUT = 10
) (
  input  logic                            global_clk,
  input  logic                            rst_n,
  input  logic                            pb_ctl,
  input  logic                            pb_pause,
  input  logic                            dip_players,
  input  logic                            game_tick,
  input  logic [3*NUM_PEERS-1:0]          peer_stat,
  input  logic [NUM_PEERS-1:0]            peer_valid,
  input  logic                            table_ready,
  input  logic                            top_out,
  output logic [2:0]                      stat_out,
  output logic [$clog2(CNT_SECS+1)-1:0]   cntdown_val,
  output logic                            paused,
  output logic [1:0]                      result,
  output logic                            stat_chg
);

  localparam int unsigned CW    = $clog2(CNT_SECS + 1);
  localparam int unsigned TW    = $clog2(MATCH_TIMEOUT + 1);
  localparam int unsigned EXT_W = 3 * MAX_PEERS;

  stat_e stat_q, stat_nxt;
  res_e  res_q, res_nxt;
  logic  mp_q, mp_nxt;
  logic  paused_q, paused_nxt;
  logic  chg_q;

  logic          cd_clr, cd_load, cd_en, cd_term;
  logic          tm_load, tm_en, tm_term;
  logic [TW-1:0] timer_cnt_unused;

  logic [EXT_W-1:0] stat_ext;
  logic             all_valid, all_search, all_ready, all_over;

  assign stat_ext   = EXT_W'(peer_stat);
  assign all_valid  = &peer_valid;
  assign all_search = peers_in_set(stat_ext, NUM_PEERS, SET_SEARCH);
  assign all_ready  = peers_in_set(stat_ext, NUM_PEERS, SET_READY);
  assign all_over   = peers_in_set(stat_ext, NUM_PEERS, SET_OVER);

  // Countdown digit lives directly in this counter's register.
  tick_down_cnt #(.WIDTH(CW)) u_cntdown (
    .clk      (global_clk),
    .rst_n    (rst_n),
    .clr      (cd_clr),
    .load     (cd_load),
    .load_val (CW'(CNT_SECS)),
    .en       (cd_en),
    .count    (cntdown_val),
    .term     (cd_term)
  );

  // Match timer counts remaining ticks down from MATCH_TIMEOUT; the tick seen
  // while one remains is the one where elapsed ticks reach MATCH_TIMEOUT.
  tick_down_cnt #(.WIDTH(TW)) u_match_timer (
    .clk      (global_clk),
    .rst_n    (rst_n),
    .clr      (1'b0),
    .load     (tm_load),
    .load_val (TW'(MATCH_TIMEOUT)),
    .en       (tm_en),
    .count    (timer_cnt_unused),
    .term     (tm_term)
  );

  always_ff @(posedge global_clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_q   <= STAT_NORMAL;
      res_q    <= RES_NONE;
      mp_q     <= 1'b0;
      paused_q <= 1'b0;
      chg_q    <= 1'b0;
    end else begin
      stat_q   <= stat_nxt;
      res_q    <= res_nxt;
      mp_q     <= mp_nxt;
      paused_q <= paused_nxt;
      chg_q    <= (stat_nxt != stat_q);
    end
  end

  always_comb begin
    stat_nxt   = stat_q;
    res_nxt    = res_q;
    mp_nxt     = mp_q;
    paused_nxt = paused_q;
    cd_clr     = 1'b0;
    cd_load    = 1'b0;
    cd_en      = 1'b0;
    tm_load    = 1'b0;
    tm_en      = 1'b0;
    case (stat_q)
      STAT_NORMAL: begin
        if (pb_ctl) begin
          mp_nxt = dip_players;
          if (dip_players) begin
            stat_nxt = STAT_MATCH_ING;
            tm_load  = 1'b1;
          end else begin
            stat_nxt = STAT_GAME_INITIAL;
          end
        end
      end
      STAT_MATCH_ING: begin
        tm_en = game_tick;
        if (all_valid && all_search)  stat_nxt = STAT_MATCH_SUCCESS;
        else if (pb_ctl)              stat_nxt = STAT_MATCH_CANCEL;
        else if (game_tick && tm_term) stat_nxt = STAT_MATCH_CANCEL;
      end
      STAT_MATCH_CANCEL: begin
        if (game_tick) stat_nxt = STAT_NORMAL;
      end
      STAT_MATCH_SUCCESS: begin
        if (!all_valid)     stat_nxt = STAT_MATCH_CANCEL;
        else if (all_ready) stat_nxt = STAT_GAME_INITIAL;
      end
      STAT_GAME_INITIAL: begin
        if (table_ready) begin
          stat_nxt = STAT_GAME_CNTDOWN;
          cd_load  = 1'b1;
        end
      end
      STAT_GAME_CNTDOWN: begin
        cd_en = game_tick;
        if (game_tick && cd_term) stat_nxt = STAT_GAME_ING;
      end
      STAT_GAME_ING: begin
        if (top_out) begin
          stat_nxt   = STAT_GAME_OVER;
          res_nxt    = RES_LOSE;
          paused_nxt = 1'b0;
        end else if (mp_q && !all_valid) begin
          stat_nxt = STAT_GAME_OVER;
          res_nxt  = RES_ABORT;
        end else if (mp_q && all_over) begin
          stat_nxt = STAT_GAME_OVER;
          res_nxt  = RES_WIN;
        end else if (!mp_q && pb_pause) begin
          paused_nxt = !paused_q;
        end
      end
      STAT_GAME_OVER: begin
        if (pb_ctl) begin
          stat_nxt   = STAT_NORMAL;
          res_nxt    = RES_NONE;
          paused_nxt = 1'b0;
          cd_clr     = 1'b1;
        end
      end
      default: stat_nxt = STAT_NORMAL;
    endcase
  end

  assign stat_out = stat_q;
  assign result   = res_q;
  assign paused   = paused_q;
  assign stat_chg = chg_q;

endmodule

// File: tb/tb_game_status_ctrl.sv
module tb_game_status_ctrl;

  localparam int NP  = 2;
  localparam int CNT = 3;
  localparam int MT  = 10;

  logic            global_clk;
  logic            rst_n;
  logic            pb_ctl, pb_pause, dip_players, game_tick;
  logic [3*NP-1:0] peer_stat;
  logic [NP-1:0]   peer_valid;
  logic            table_ready, top_out;
  logic [2:0]      stat_out;
  logic [1:0]      cntdown_val;
  logic            paused;
  logic [1:0]      result;
  logic            stat_chg;

  game_status_ctrl #(.NUM_PEERS(NP), .CNT_SECS(CNT), .MATCH_TIMEOUT(MT)) dut (
    .global_clk  (global_clk),
    .rst_n       (rst_n),
    .pb_ctl      (pb_ctl),
    .pb_pause    (pb_pause),
    .dip_players (dip_players),
    .game_tick   (game_tick),
    .peer_stat   (peer_stat),
    .peer_valid  (peer_valid),
    .table_ready (table_ready),
    .top_out     (top_out),
    .stat_out    (stat_out),
    .cntdown_val (cntdown_val),
    .paused      (paused),
    .result      (result),
    .stat_chg    (stat_chg)
  );

  initial global_clk = 1'b0;
  always #5 global_clk = ~global_clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [8:0] dut_vec;
  logic [8:0] exp_v;
  assign dut_vec = {stat_out, cntdown_val, paused, result, stat_chg};

  function automatic logic [8:0] ev(input logic [2:0] s, input logic [1:0] c,
                                    input logic p, input logic [1:0] r, input logic ch);
    return {s, c, p, r, ch};
  endfunction

  // ---------------- behavioural reference model ----------------
  // States are plain integers 0..7 matching the status codes; the match
  // timer counts elapsed ticks upward, the countdown counts remaining ticks.
  int m_stat, m_elapsed, m_remaining, m_result;
  bit m_mp, m_paused, m_chg;

  task automatic model_reset();
    m_stat = 0; m_elapsed = 0; m_remaining = 0; m_result = 0;
    m_mp = 0; m_paused = 0; m_chg = 0;
  endtask

  task automatic model_step();
    int prev, c;
    bit allv, srch, rdy, over;
    prev = m_stat;
    allv = (peer_valid == {NP{1'b1}});
    srch = 1; rdy = 1; over = 1;
    for (int i = 0; i < NP; i++) begin
      c = int'(peer_stat[3*i +: 3]);
      if (!(c == 1 || c == 3)) srch = 0;
      if (c < 3) rdy = 0;
      if (c != 7) over = 0;
    end
    case (m_stat)
      0: if (pb_ctl) begin
           m_mp = dip_players;
           if (dip_players) begin m_stat = 1; m_elapsed = 0; end
           else m_stat = 4;
         end
      1: if (allv && srch) m_stat = 3;
         else if (pb_ctl) m_stat = 2;
         else if (game_tick) begin
           m_elapsed++;
           if (m_elapsed >= MT) m_stat = 2;
         end
      2: if (game_tick) m_stat = 0;
      3: if (!allv) m_stat = 2; else if (rdy) m_stat = 4;
      4: if (table_ready) begin m_stat = 5; m_remaining = CNT; end
      5: if (game_tick) begin
           m_remaining--;
           if (m_remaining == 0) m_stat = 6;
         end
      6: if (top_out) begin m_stat = 7; m_result = 2; m_paused = 0; end
         else if (m_mp && !allv) begin m_stat = 7; m_result = 3; end
         else if (m_mp && over) begin m_stat = 7; m_result = 1; end
         else if (!m_mp && pb_pause) m_paused = !m_paused;
      default: if (pb_ctl) begin
           m_stat = 0; m_result = 0; m_paused = 0; m_remaining = 0;
         end
    endcase
    m_chg = (m_stat != prev);
  endtask

  function automatic logic [8:0] model_vec();
    return {3'(m_stat), 2'(m_remaining), m_paused, 2'(m_result), m_chg};
  endfunction

  // One clock cycle with the given pulse inputs; outputs sampled #1 after the edge.
  task automatic cyc(input logic ctl = 1'b0, input logic pause = 1'b0, input logic tick = 1'b0);
    pb_ctl = ctl; pb_pause = pause; game_tick = tick;
    @(posedge global_clk);
    model_step();
    #1;
    pb_ctl = 1'b0; pb_pause = 1'b0; game_tick = 1'b0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #12;
    model_reset();
    rst_n = 1'b1;
    @(posedge global_clk);
    #1;
  endtask

  // Drive a multiplayer session from NORMAL into GAME_ING.
  task automatic goto_mp_game();
    dip_players = 1'b1; peer_valid = 2'b11; peer_stat = {3'b011, 3'b011};
    cyc(1'b1);
    cyc();
    cyc();
    table_ready = 1'b1; cyc(); table_ready = 1'b0;
    for (int i = 0; i < CNT; i++) cyc(1'b0, 1'b0, 1'b1);
    peer_stat = {3'b100, 3'b100};
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    apply_reset();
    n_checks++; if (stat_out !== 3'b000) begin n_fail++; $display("FAIL reset_stat: got %b expected 000", stat_out); end
    n_checks++; if (cntdown_val !== 2'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d expected 0", cntdown_val); end
    n_checks++; if ({paused, result, stat_chg} !== 4'b0) begin n_fail++; $display("FAIL reset_flags: got %b expected 0000", {paused, result, stat_chg}); end
  endtask

  task automatic test_single_player();
    int pulses;
    pulses = 0;
    dip_players = 1'b0;
    cyc(1'b1); pulses += int'(stat_chg);
    exp_v = ev(3'b100, 2'd0, 0, 2'd0, 1); n_checks++;
    if (dut_vec !== exp_v) begin n_fail++; $display("FAIL sp_init: got %b expected %b", dut_vec, exp_v); end
    table_ready = 1'b1; cyc(); table_ready = 1'b0; pulses += int'(stat_chg);
    exp_v = ev(3'b101, 2'd3, 0, 2'd0, 1); n_checks++;
    if (dut_vec !== exp_v) begin n_fail++; $display("FAIL sp_cnt3: got %b expected %b", dut_vec, exp_v); end
    cyc(); pulses += int'(stat_chg);
    exp_v = ev(3'b101, 2'd3, 0, 2'd0, 0); n_checks++;
    if (dut_vec !== exp_v) begin n_fail++; $display("FAIL sp_hold: got %b expected %b", dut_vec, exp_v); end
    cyc(1'b0, 1'b0, 1'b1); pulses += int'(stat_chg);
    exp_v = ev(3'b101, 2'd2, 0, 2'd0, 0); n_checks++;
    if (dut_vec !== exp_v) begin n_fail++; $display("FAIL sp_cnt2: got %b expected %b", dut_vec, exp_v); end
    cyc(1'b0, 1'b0, 1'b1); pulses += int'(stat_chg);
    exp_v = ev(3'b101, 2'd1, 0, 2'd0, 0); n_checks++;
    if (dut_vec !== exp_v) begin n_fail++; $display("FAIL sp_cnt1: got %b expected %b", dut_vec, exp_v); end
    cyc(1'b0, 1'b0, 1'b1); pulses += int'(stat_chg);
    exp_v = ev(3'b110, 2'd0, 0, 2'd0, 1); n_checks++;
    if (dut_vec !== exp_v) begin n_fail++; $display("FAIL sp_play: got %b expected %b", dut_vec, exp_v); end
    n_checks++; if (pulses != 3) begin n_fail++; $display("FAIL sp_chg_count: got %0d expected 3", pulses); end
    cyc(1'b0, 1'b1);
    n_checks++; if (paused !== 1'b1) begin n_fail++; $display("FAIL sp_pause_on: got %b expected 1", paused); end
    cyc(1'b0, 1'b1);
    n_checks++; if (paused !== 1'b0) begin n_fail++; $display("FAIL sp_pause_off: got %b expected 0", paused); end
    cyc(1'b1, 1'b1);
    top_out = 1'b1; cyc(); top_out = 1'b0;
    exp_v = ev(3'b111, 2'd0, 0, 2'd2, 1); n_checks++;
    if (dut_vec !== exp_v) begin n_fail++; $display("FAIL sp_lose_paused: got %b expected %b", dut_vec, exp_v); end
    cyc();
    exp_v = ev(3'b111, 2'd0, 0, 2'd2, 0); n_checks++;
    if (dut_vec !== exp_v) begin n_fail++; $display("FAIL sp_over_hold: got %b expected %b", dut_vec, exp_v); end
    cyc(1'b1);
    exp_v = ev(3'b000, 2'd0, 0, 2'd0, 1); n_checks++;
    if (dut_vec !== exp_v) begin n_fail++; $display("FAIL sp_back_normal: got %b expected %b", dut_vec, exp_v); end
  endtask

  task automatic test_mp_match();
    dip_players = 1'b1; peer_valid = 2'b11; peer_stat = '0;
    cyc(1'b1);
    n_checks++; if (stat_out !== 3'b001) begin n_fail++; $display("FAIL mp_matching: got %b expected 001", stat_out); end
    peer_stat = {3'b001, 3'b011}; cyc();
    n_checks++; if (stat_out !== 3'b011) begin n_fail++; $display("FAIL mp_success: got %b expected 011", stat_out); end
    peer_stat = {3'b100, 3'b011}; dip_players = 1'b0; cyc();
    n_checks++; if (stat_out !== 3'b100) begin n_fail++; $display("FAIL mp_initial: got %b expected 100", stat_out); end
    table_ready = 1'b1; cyc(); table_ready = 1'b0;
    for (int i = 0; i < CNT; i++) cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b1);
    exp_v = ev(3'b110, 2'd0, 0, 2'd0, 0); n_checks++;
    if (dut_vec !== exp_v) begin n_fail++; $display("FAIL mp_pause_ignored: got %b expected %b", dut_vec, exp_v); end
    peer_stat = {3'b111, 3'b111}; top_out = 1'b1; cyc(); top_out = 1'b0;
    exp_v = ev(3'b111, 2'd0, 0, 2'd2, 1); n_checks++;
    if (dut_vec !== exp_v) begin n_fail++; $display("FAIL mp_lose_prio: got %b expected %b", dut_vec, exp_v); end
    cyc(1'b1);
    n_checks++; if ({stat_out, result} !== 5'b000_00) begin n_fail++; $display("FAIL mp_clear: got %b expected 00000", {stat_out, result}); end
    peer_stat = '0;
  endtask

  task automatic test_mp_end();
    goto_mp_game();
    n_checks++; if (stat_out !== 3'b110) begin n_fail++; $display("FAIL mp_reach_game: got %b expected 110", stat_out); end
    peer_valid = 2'b01; cyc();
    exp_v = ev(3'b111, 2'd0, 0, 2'd3, 1); n_checks++;
    if (dut_vec !== exp_v) begin n_fail++; $display("FAIL mp_abort: got %b expected %b", dut_vec, exp_v); end
    peer_valid = 2'b11; cyc(1'b1);
    goto_mp_game();
    peer_stat = {3'b111, 3'b111}; cyc();
    exp_v = ev(3'b111, 2'd0, 0, 2'd1, 1); n_checks++;
    if (dut_vec !== exp_v) begin n_fail++; $display("FAIL mp_win: got %b expected %b", dut_vec, exp_v); end
    cyc(1'b1); peer_stat = '0;
  endtask

  task automatic test_timeout();
    dip_players = 1'b1; peer_valid = 2'b11; peer_stat = '0;
    cyc(1'b1);
    for (int i = 0; i < MT - 1; i++) begin cyc(1'b0, 1'b0, 1'b1); cyc(); end
    n_checks++; if (stat_out !== 3'b001) begin n_fail++; $display("FAIL to_before: got %b expected 001", stat_out); end
    cyc(1'b0, 1'b0, 1'b1);
    n_checks++; if ({stat_out, stat_chg} !== 4'b010_1) begin n_fail++; $display("FAIL to_cancel: got %b expected 0101", {stat_out, stat_chg}); end
    cyc(); cyc();
    n_checks++; if (stat_out !== 3'b010) begin n_fail++; $display("FAIL to_cancel_hold: got %b expected 010", stat_out); end
    cyc(1'b0, 1'b0, 1'b1);
    n_checks++; if (stat_out !== 3'b000) begin n_fail++; $display("FAIL to_normal: got %b expected 000", stat_out); end
    cyc(1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b1);
    n_checks++; if (stat_out !== 3'b010) begin n_fail++; $display("FAIL to_early_cancel: got %b expected 010", stat_out); end
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b1);
    peer_stat = {3'b001, 3'b001}; cyc(1'b1);
    n_checks++; if (stat_out !== 3'b011) begin n_fail++; $display("FAIL to_success_prio: got %b expected 011", stat_out); end
    peer_valid = 2'b10; cyc();
    n_checks++; if (stat_out !== 3'b010) begin n_fail++; $display("FAIL to_success_drop: got %b expected 010", stat_out); end
    peer_valid = 2'b11; peer_stat = '0; cyc(1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_async_reset();
    dip_players = 1'b0;
    cyc(1'b1);
    table_ready = 1'b1; cyc(); table_ready = 1'b0;
    cyc(1'b0, 1'b0, 1'b1);
    n_checks++; if (cntdown_val !== 2'd2) begin n_fail++; $display("FAIL ar_setup: got %0d expected 2", cntdown_val); end
    #2;
    rst_n = 1'b0;
    #1;
    exp_v = ev(3'b000, 2'd0, 0, 2'd0, 0); n_checks++;
    if (dut_vec !== exp_v) begin n_fail++; $display("FAIL ar_immediate: got %b expected %b", dut_vec, exp_v); end
    model_reset();
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    for (int k = 0; k < 3000; k++) begin
      dip_players = 1'($urandom_range(1));
      table_ready = 1'($urandom_range(1));
      top_out     = ($urandom_range(39) == 0);
      peer_valid  = ($urandom_range(15) == 0) ? 2'($urandom_range(2)) : 2'b11;
      for (int i = 0; i < NP; i++) peer_stat[3*i +: 3] = 3'($urandom_range(7));
      cyc(($urandom_range(7) == 0), ($urandom_range(7) == 0), ($urandom_range(3) == 0));
      exp_v = model_vec(); n_checks++;
      if (dut_vec !== exp_v) begin
        n_fail++;
        $display("FAIL rand_cycle%0d: got %b expected %b", k, dut_vec, exp_v);
      end
    end
    top_out = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; pb_ctl = 1'b0; pb_pause = 1'b0; dip_players = 1'b0;
    game_tick = 1'b0; peer_stat = '0; peer_valid = '1; table_ready = 1'b0; top_out = 1'b0;
    model_reset();
    test_reset();
    test_single_player();
    test_mp_match();
    test_mp_end();
    test_timeout();
    test_async_reset();
    test_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
